// File: rtl/qed_chk_pkg.sv
// Shared types and elaboration helpers for the QED consistency monitor.
// Holds the FSM state type, default sizing and parameter legality checks.
package qed_chk_pkg;

   typedef enum logic [1:0] {StIdle, StSnap, StScan, StReport} qed_state_e;

   localparam int unsigned HALF = 16;

   function automatic int unsigned scan_cycles(int unsigned half, int unsigned lanes,
                                               int unsigned skip_zero);
      return (half - skip_zero + lanes - 1) / lanes;
   endfunction

   function automatic bit params_ok(int unsigned num_regs, int unsigned lanes,
                                    int unsigned skip_zero);
      return (num_regs % 2 == 0) && (num_regs >= 2) && (lanes >= 1) &&
             (lanes <= num_regs / 2) && (skip_zero <= 1) && (num_regs / 2 > skip_zero);
   endfunction

endpackage

// File: rtl/qed_pair_cmp_lane.sv
// Combinational LANES-wide register-pair comparator.
// Reports whether any valid lane differs and the lowest such lane with its values.
module qed_pair_cmp_lane
   import qed_chk_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned XLEN  = 32,
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [LANES*XLEN-1:0] orig_i,
   input  logic [LANES*XLEN-1:0] dup_i,
   input  logic [LANES-1:0]      valid_i,
   output logic                  any_mismatch_o,
   output logic [LANE_W-1:0]     lane_o,
   output logic [XLEN-1:0]       orig_o,
   output logic [XLEN-1:0]       dup_o
);

   logic [LANES-1:0] diff;

   always_comb begin
      diff           = '0;
      any_mismatch_o = 1'b0;
      lane_o         = '0;
      orig_o         = '0;
      dup_o          = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         diff[l] = valid_i[l] && (orig_i[l*XLEN +: XLEN] != dup_i[l*XLEN +: XLEN]);
      end
      any_mismatch_o = |diff;
      // Walk downwards so the lowest differing lane is the one left standing.
      for (int l = int'(LANES) - 1; l >= 0; l--) begin
         if (diff[l]) begin
            lane_o = LANE_W'(l);
            orig_o = orig_i[l*XLEN +: XLEN];
            dup_o  = dup_i[l*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/qed_consistency_monitor.sv
// QED consistency monitor: counts original/duplicate commits and, at each consistent
// point, snapshots the register file and compares orig/dup pairs LANES at a time.
module qed_consistency_monitor
   import qed_chk_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned LANES     = 4,
   parameter int unsigned SKIP_ZERO = 1,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned HALF_R   = NUM_REGS / 2,
   localparam int unsigned IDX_W    = (HALF_R > 1) ? $clog2(HALF_R) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     chk_en_i,
   input  logic                     orig_commit_i,
   input  logic                     dup_commit_i,
   input  logic [NUM_REGS*XLEN-1:0] regs_flat_i,
   output logic                     busy_o,
   output logic                     check_done_o,
   output logic                     mismatch_o,
   output logic [IDX_W-1:0]         mismatch_idx_o,
   output logic [XLEN-1:0]          mismatch_orig_o,
   output logic [XLEN-1:0]          mismatch_dup_o,
   output logic                     order_err_o,
   output logic [CNT_W-1:0]         check_count_o,
   output logic [CNT_W-1:0]         missed_count_o
);

   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned SCAN_W = $clog2(HALF_R + LANES + 1);
   localparam int unsigned NCYC   = scan_cycles(HALF_R, LANES, SKIP_ZERO);

   if (!params_ok(NUM_REGS, LANES, SKIP_ZERO)) begin : g_param_err
      $error("qed_consistency_monitor: illegal NUM_REGS/LANES/SKIP_ZERO");
   end

   qed_state_e                state_q, state_d;
   logic [CNT_W-1:0]          orig_cnt_q, dup_cnt_q, orig_nx, dup_nx;
   logic [CNT_W-1:0]          check_cnt_q, missed_cnt_q;
   logic [SCAN_W-1:0]         scan_idx_q, scan_idx_d, scan_left_q, scan_left_d;
   logic [NUM_REGS*XLEN-1:0]  snap_q;
   logic                      mismatch_q, order_err_q;
   logic [IDX_W-1:0]          mm_idx_q;
   logic [XLEN-1:0]           mm_orig_q, mm_dup_q;
   logic                      trigger, order_hit;

   logic [LANES*XLEN-1:0]     grp_orig, grp_dup;
   logic [LANES-1:0]          grp_valid;
   logic                      any_mm;
   logic [LANE_W-1:0]         mm_lane;
   logic [XLEN-1:0]           mm_orig_val, mm_dup_val;

   assign orig_nx   = orig_cnt_q + CNT_W'(orig_commit_i);
   assign dup_nx    = dup_cnt_q + CNT_W'(dup_commit_i);
   assign trigger   = chk_en_i & dup_commit_i & (orig_nx == dup_nx);
   assign order_hit = dup_commit_i & ~orig_commit_i & (dup_cnt_q == orig_cnt_q);

   // Gather the current scan group; lanes past the last original register are masked off.
   always_comb begin
      grp_orig  = '0;
      grp_dup   = '0;
      grp_valid = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (32'(scan_idx_q) + l < HALF_R) begin
            grp_valid[l]              = 1'b1;
            grp_orig[l*XLEN +: XLEN] = snap_q[(32'(scan_idx_q) + l)*XLEN +: XLEN];
            grp_dup[l*XLEN +: XLEN]  = snap_q[(32'(scan_idx_q) + l + HALF_R)*XLEN +: XLEN];
         end
      end
   end

   qed_pair_cmp_lane #(
      .LANES (LANES),
      .XLEN  (XLEN)
   ) u_cmp (
      .orig_i         (grp_orig),
      .dup_i          (grp_dup),
      .valid_i        (grp_valid),
      .any_mismatch_o (any_mm),
      .lane_o         (mm_lane),
      .orig_o         (mm_orig_val),
      .dup_o          (mm_dup_val)
   );

   always_comb begin
      state_d     = state_q;
      scan_idx_d  = scan_idx_q;
      scan_left_d = scan_left_q;
      unique case (state_q)
         StIdle: if (trigger) state_d = StSnap;
         StSnap: begin
            state_d     = StScan;
            scan_idx_d  = SCAN_W'(SKIP_ZERO);
            scan_left_d = SCAN_W'(NCYC - 1);
         end
         StScan: begin
            scan_idx_d  = scan_idx_q + SCAN_W'(LANES);
            scan_left_d = scan_left_q - SCAN_W'(1);
            if (any_mm || scan_left_q == '0) state_d = StReport;
         end
         StReport: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         orig_cnt_q   <= '0;
         dup_cnt_q    <= '0;
         check_cnt_q  <= '0;
         missed_cnt_q <= '0;
         scan_idx_q   <= '0;
         scan_left_q  <= '0;
         snap_q       <= '0;
         mismatch_q   <= 1'b0;
         order_err_q  <= 1'b0;
         mm_idx_q     <= '0;
         mm_orig_q    <= '0;
         mm_dup_q     <= '0;
      end else begin
         state_q     <= state_d;
         orig_cnt_q  <= orig_nx;
         dup_cnt_q   <= dup_nx;
         scan_idx_q  <= scan_idx_d;
         scan_left_q <= scan_left_d;
         if (order_hit) order_err_q <= 1'b1;
         if (trigger && state_q != StIdle && missed_cnt_q != '1) begin
            missed_cnt_q <= missed_cnt_q + CNT_W'(1);
         end
         if (state_q == StSnap) snap_q <= regs_flat_i;
         if (state_q == StReport && check_cnt_q != '1) check_cnt_q <= check_cnt_q + CNT_W'(1);
         if (state_q == StScan && any_mm) begin
            mismatch_q <= 1'b1;
            if (!mismatch_q) begin
               mm_idx_q  <= IDX_W'(32'(scan_idx_q) + 32'(mm_lane));
               mm_orig_q <= mm_orig_val;
               mm_dup_q  <= mm_dup_val;
            end
         end
      end
   end

   assign busy_o          = (state_q != StIdle);
   assign check_done_o    = (state_q == StReport);
   assign mismatch_o      = mismatch_q;
   assign mismatch_idx_o  = mm_idx_q;
   assign mismatch_orig_o = mm_orig_q;
   assign mismatch_dup_o  = mm_dup_q;
   assign order_err_o     = order_err_q;
   assign check_count_o   = check_cnt_q;
   assign missed_count_o  = missed_cnt_q;

endmodule

// File: tb/tb_qed_consistency_monitor.sv
// Directed bench for qed_consistency_monitor: default instance plus SKIP_ZERO=0
// and CNT_W=4 instances sharing the same stimulus.
module tb_qed_consistency_monitor;

   localparam int unsigned NR = 32;
   localparam int unsigned XL = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             chk_en = 1'b0;
   logic             orig_commit = 1'b0;
   logic             dup_commit = 1'b0;
   logic [NR*XL-1:0] regs_flat = '0;

   logic        a_busy, a_done, a_mm, a_oerr;
   logic [3:0]  a_idx;
   logic [31:0] a_orig, a_dup;
   logic [15:0] a_cnt, a_missed;
   logic        z_busy, z_done, z_mm, z_oerr;
   logic [3:0]  z_idx;
   logic [31:0] z_orig, z_dup;
   logic [15:0] z_cnt, z_missed;
   logic        w_busy, w_done, w_mm, w_oerr;
   logic [3:0]  w_idx;
   logic [31:0] w_orig, w_dup;
   logic [3:0]  w_cnt, w_missed;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int a_done_n = 0, a_done_cyc = 0, z_done_n = 0, z_done_cyc = 0, w_done_n = 0;
   int t, base, zbase;

   qed_consistency_monitor u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .chk_en_i(chk_en), .orig_commit_i(orig_commit),
      .dup_commit_i(dup_commit), .regs_flat_i(regs_flat), .busy_o(a_busy),
      .check_done_o(a_done), .mismatch_o(a_mm), .mismatch_idx_o(a_idx),
      .mismatch_orig_o(a_orig), .mismatch_dup_o(a_dup), .order_err_o(a_oerr),
      .check_count_o(a_cnt), .missed_count_o(a_missed)
   );

   qed_consistency_monitor #(.SKIP_ZERO(0)) u_dut_z (
      .clk_i(clk), .rst_ni(rst_n), .chk_en_i(chk_en), .orig_commit_i(orig_commit),
      .dup_commit_i(dup_commit), .regs_flat_i(regs_flat), .busy_o(z_busy),
      .check_done_o(z_done), .mismatch_o(z_mm), .mismatch_idx_o(z_idx),
      .mismatch_orig_o(z_orig), .mismatch_dup_o(z_dup), .order_err_o(z_oerr),
      .check_count_o(z_cnt), .missed_count_o(z_missed)
   );

   qed_consistency_monitor #(.CNT_W(4)) u_dut_w (
      .clk_i(clk), .rst_ni(rst_n), .chk_en_i(chk_en), .orig_commit_i(orig_commit),
      .dup_commit_i(dup_commit), .regs_flat_i(regs_flat), .busy_o(w_busy),
      .check_done_o(w_done), .mismatch_o(w_mm), .mismatch_idx_o(w_idx),
      .mismatch_orig_o(w_orig), .mismatch_dup_o(w_dup), .order_err_o(w_oerr),
      .check_count_o(w_cnt), .missed_count_o(w_missed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_done) begin
         a_done_n   = a_done_n + 1;
         a_done_cyc = cyc;
      end
      if (z_done) begin
         z_done_n   = z_done_n + 1;
         z_done_cyc = cyc;
      end
      if (w_done) w_done_n = w_done_n + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic o, input logic d);
      orig_commit = o;
      dup_commit  = d;
      tick(1);
      orig_commit = 1'b0;
      dup_commit  = 1'b0;
   endtask

   task automatic set_reg(input int k, input logic [31:0] v);
      regs_flat[k*XL +: XL] = v;
   endtask

   task automatic default_regs();
      for (int k = 0; k < int'(NR); k++) set_reg(k, 32'h100 + 32'(k % 16));
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      chk_en      = 1'b0;
      orig_commit = 1'b0;
      dup_commit  = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      // Reset state
      default_regs();
      tick(1);
      check_val("rst_busy", a_busy, 0);
      check_val("rst_done", a_done, 0);
      check_val("rst_mm", a_mm, 0);
      check_val("rst_cnt", a_cnt, 0);
      check_val("rst_missed", a_missed, 0);
      do_reset();

      // Clean check: 3 orig, 3 dup
      chk_en = 1'b1;
      repeat (3) drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      t = cyc;
      base = a_done_n;
      drive(1'b0, 1'b1);
      check_val("clean_busy", a_busy, 1);
      tick(10);
      check_val("clean_done_n", 64'(a_done_n - base), 1);
      check_val("clean_done_cyc", 64'(a_done_cyc), 64'(t + 6));
      check_val("clean_mm", a_mm, 0);
      check_val("clean_cnt", a_cnt, 1);
      check_val("clean_idle", a_busy, 0);

      // Fault detection with early stop, then a clean check keeps first failure
      do_reset();
      default_regs();
      set_reg(5, 32'h1234);
      set_reg(21, 32'h1235);
      set_reg(9, 32'hAAAA);
      set_reg(25, 32'hBBBB);
      chk_en = 1'b1;
      drive(1'b1, 1'b0);
      t = cyc;
      drive(1'b0, 1'b1);
      tick(10);
      check_val("fault_done_cyc", 64'(a_done_cyc), 64'(t + 4));
      check_val("fault_mm", a_mm, 1);
      check_val("fault_idx", a_idx, 5);
      check_val("fault_orig", a_orig, 32'h1234);
      check_val("fault_dup", a_dup, 32'h1235);
      default_regs();
      drive(1'b1, 1'b0);
      base = a_done_n;
      drive(1'b0, 1'b1);
      tick(10);
      check_val("keep_done_n", 64'(a_done_n - base), 1);
      check_val("keep_cnt", a_cnt, 2);
      check_val("keep_idx", a_idx, 5);
      check_val("keep_orig", a_orig, 32'h1234);
      check_val("keep_dup", a_dup, 32'h1235);

      // Skip-zero: pair 0 differs
      do_reset();
      default_regs();
      set_reg(0, 32'h0);
      set_reg(16, 32'hFFFF_FFFF);
      chk_en = 1'b1;
      drive(1'b1, 1'b0);
      t = cyc;
      drive(1'b0, 1'b1);
      tick(10);
      check_val("skip_mm", a_mm, 0);
      check_val("skip_done_cyc", 64'(a_done_cyc), 64'(t + 6));
      check_val("noskip_mm", z_mm, 1);
      check_val("noskip_idx", z_idx, 0);
      check_val("noskip_orig", z_orig, 0);
      check_val("noskip_dup", z_dup, 32'hFFFF_FFFF);
      check_val("noskip_done_cyc", 64'(z_done_cyc), 64'(t + 3));

      // Overlapping trigger, then ordering error
      do_reset();
      default_regs();
      chk_en = 1'b1;
      drive(1'b1, 1'b0);
      base = a_done_n;
      drive(1'b0, 1'b1);
      tick(1);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      tick(10);
      check_val("ovl_missed", a_missed, 1);
      check_val("ovl_done_n", 64'(a_done_n - base), 1);
      check_val("ovl_cnt", a_cnt, 1);
      check_val("ovl_oerr0", a_oerr, 0);
      drive(1'b0, 1'b1);
      check_val("order_err", a_oerr, 1);
      check_val("order_busy", a_busy, 0);

      // Asynchronous reset mid-scan after a failing check
      do_reset();
      default_regs();
      set_reg(5, 32'h1234);
      set_reg(21, 32'h1235);
      chk_en = 1'b1;
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      tick(10);
      check_val("pre_rst_mm", a_mm, 1);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      tick(3);
      check_val("pre_rst_busy", a_busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("arst_busy", a_busy, 0);
      check_val("arst_mm", a_mm, 0);
      check_val("arst_idx", a_idx, 0);
      check_val("arst_orig", a_orig, 0);
      check_val("arst_dup", a_dup, 0);
      check_val("arst_cnt", a_cnt, 0);
      base = a_done_n;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      check_val("arst_no_done", 64'(a_done_n - base), 0);

      // chk_en low: no checks, but commits still counted
      do_reset();
      default_regs();
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      check_val("dis_busy", a_busy, 0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      check_val("dis_busy2", a_busy, 0);
      chk_en = 1'b1;
      base = a_done_n;
      t = cyc;
      drive(1'b0, 1'b1);
      tick(10);
      check_val("en_done_n", 64'(a_done_n - base), 1);
      check_val("en_done_cyc", 64'(a_done_cyc), 64'(t + 6));
      check_val("en_oerr", a_oerr, 0);
      check_val("en_cnt", a_cnt, 1);

      // Counter wrap with CNT_W=4 and check_count saturation
      do_reset();
      default_regs();
      chk_en = 1'b1;
      base  = w_done_n;
      zbase = a_done_n;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0);
         drive(1'b0, 1'b1);
         tick(6);
         if (i == 14) check_val("wrap_cnt15", w_cnt, 15);
      end
      check_val("wrap_done_n", 64'(w_done_n - base), 20);
      check_val("wrap_oerr", w_oerr, 0);
      check_val("wrap_missed", w_missed, 0);
      check_val("wrap_sat", w_cnt, 15);
      check_val("wrap_wide_cnt", a_cnt, 20);
      check_val("wrap_wide_done", 64'(a_done_n - zbase), 20);
      check_val("wrap_mm", w_mm, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
